// File: rtl/arb_pkg.sv
// State encoding and default timing constants shared by the requester and the arbiter bench.
package arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;
  localparam logic [1:0] ST_REL  = 2'd3;

  localparam int TIMEOUT_DEF  = 16;
  localparam int IDLE_GAP_DEF = 1;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_REQ  = ST_REQ,
    S_XFER = ST_XFER,
    S_REL  = ST_REL
  } state_e;

endpackage

// File: rtl/arb_requester.sv
// Client side of the arbiter req/grant handshake: start->req 1 cycle, grant->beat 1 cycle, last beat->done 1 cycle.
// Grant acts as backpressure: beats stall (req held) while grant is low in XFER; start is dropped outside IDLE.
module arb_requester
  import arb_pkg::*;
#(
  parameter int LEN_W    = 4,
  parameter int TIMEOUT  = TIMEOUT_DEF,
  parameter int IDLE_GAP = IDLE_GAP_DEF
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             grant,
  output logic             req,
  output logic             busy,
  output logic             xfer_en,
  output logic             done,
  output logic             timeout_err
);

  localparam logic [7:0]       WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [3:0]       GAP_LAST  = 4'(IDLE_GAP - 1);
  localparam logic [LEN_W-1:0] BEAT_ONE  = LEN_W'(1);

  state_e           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic             req_q, req_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tmo_q, tmo_d;

  // Combinational so the beat lines up with the arbiter's registered grant.
  assign xfer_en     = (state_q == S_XFER) && grant;
  assign req         = req_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = tmo_q;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    beat_cnt_d = beat_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    done_d     = 1'b0;
    tmo_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && (burst_len != '0)) begin
          beat_cnt_d = burst_len;
          wait_cnt_d = '0;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        if (grant) begin
          state_d = S_XFER;
        end else begin
          if (wait_cnt_q != 8'hFF) wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_q == WAIT_LAST) begin
            state_d   = S_REL;
            gap_cnt_d = '0;
            tmo_d     = 1'b1;
          end
        end
      end
      S_XFER: begin
        if (grant) begin
          beat_cnt_d = beat_cnt_q - BEAT_ONE;
          if (beat_cnt_q == BEAT_ONE) begin
            state_d   = S_REL;
            gap_cnt_d = '0;
            done_d    = 1'b1;
          end
        end
      end
      S_REL: begin
        if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
        else                       gap_cnt_d = gap_cnt_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
    req_d  = (state_d == S_REQ) || (state_d == S_XFER);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      beat_cnt_q <= '0;
      gap_cnt_q  <= '0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
    end
  end

endmodule

// File: tb/tb_arb_requester.sv
// Scoreboard bench: expected burst outcomes are queued at stimulus time, popped by a monitor on done/timeout_err.
module tb_arb_requester;

  typedef struct packed {
    logic [7:0] kind;   // 1 = done, 2 = timeout
    logic [7:0] beats;
  } evt_t;

  logic       clk = 1'b0;
  logic       rest = 1'b1;
  logic       start = 1'b0;
  logic       start1 = 1'b0;
  logic [3:0] burst_len = 4'd0;
  logic [3:0] len1 = 4'd0;
  logic       grant = 1'b0;
  logic       arb_mode = 1'b0;
  logic       ag0, ag1, last_g;
  logic       g0, g1;
  logic       req, busy, xfer_en, done, timeout_err;
  logic       req1, busy1, xfer_en1, done1, tmo1;

  int   checks = 0;
  int   errors = 0;
  int   b0 = 0;
  int   b1 = 0;
  evt_t q0[$];
  evt_t q1[$];

  always #5 clk = ~clk;

  assign g0 = arb_mode ? ag0 : grant;
  assign g1 = arb_mode ? ag1 : 1'b0;

  arb_requester u0 (
    .clk(clk), .rest(rest), .start(start), .burst_len(burst_len), .grant(g0),
    .req(req), .busy(busy), .xfer_en(xfer_en), .done(done), .timeout_err(timeout_err)
  );

  arb_requester u1 (
    .clk(clk), .rest(rest), .start(start1), .burst_len(len1), .grant(g1),
    .req(req1), .busy(busy1), .xfer_en(xfer_en1), .done(done1), .timeout_err(tmo1)
  );

  // Small round-robin arbiter with a registered grant, held while the owner keeps req high.
  always @(posedge clk or posedge rest) begin
    if (rest) begin
      ag0 <= 1'b0; ag1 <= 1'b0; last_g <= 1'b1;
    end else if (!arb_mode) begin
      ag0 <= 1'b0; ag1 <= 1'b0;
    end else if (ag0 && req) begin
      ag0 <= 1'b1;
    end else if (ag1 && req1) begin
      ag1 <= 1'b1;
    end else if (req && (!req1 || last_g)) begin
      ag0 <= 1'b1; ag1 <= 1'b0; last_g <= 1'b0;
    end else if (req1) begin
      ag0 <= 1'b0; ag1 <= 1'b1; last_g <= 1'b1;
    end else begin
      ag0 <= 1'b0; ag1 <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic pop_chk(input int inst, input int kind, input int beats);
    evt_t e;
    logic have;
    have = 1'b0;
    e    = '0;
    if (inst == 0) begin
      if (q0.size() != 0) begin e = q0.pop_front(); have = 1'b1; end
    end else begin
      if (q1.size() != 0) begin e = q1.pop_front(); have = 1'b1; end
    end
    chk($sformatf("u%0d_event_expected", inst), have, 1);
    if (have) begin
      chk($sformatf("u%0d_event_kind", inst), kind, e.kind);
      chk($sformatf("u%0d_beat_count", inst), beats, e.beats);
    end
  endtask

  // Monitor: counts beats per instance and checks each burst outcome against the queue.
  always @(negedge clk) begin
    if (rest) begin
      b0 = 0;
      b1 = 0;
    end else begin
      if (xfer_en)  b0++;
      if (xfer_en1) b1++;
      if (done || timeout_err) begin
        chk("u0_done_tmo_exclusive", done & timeout_err, 0);
        pop_chk(0, done ? 1 : 2, b0);
        b0 = 0;
      end
      if (done1 || tmo1) begin
        chk("u1_done_tmo_exclusive", done1 & tmo1, 0);
        pop_chk(1, done1 ? 1 : 2, b1);
        b1 = 0;
      end
      if (arb_mode) begin
        chk("grant_overlap", ag0 & ag1, 0);
        chk("xfer_overlap", xfer_en & xfer_en1, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic issue_start(input logic [3:0] len);
    start     = 1'b1;
    burst_len = len;
    step();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      step();
      n++;
    end
    chk(name, done, 1);
  endtask

  initial begin
    logic [5:0] pat;
    int n, k;

    // Reset state
    smp();
    chk("rst_outputs", {req, busy, xfer_en, done, timeout_err}, 0);
    step();
    step();
    rest = 1'b0;

    // Idle with no start
    for (int i = 0; i < 20; i++) begin
      smp();
      chk("idle_outputs", {req, busy, xfer_en, done, timeout_err}, 0);
      step();
    end

    // len=3, grant held
    q0.push_back('{8'd1, 8'd3});
    issue_start(4'd3);
    smp();
    chk("t2_req_latency", req, 1);
    chk("t2_busy", busy, 1);
    step();
    grant = 1'b1;
    smp();
    chk("t2_no_early_xfer", xfer_en, 0);
    step();
    smp();
    chk("t2_first_beat", xfer_en, 1);
    wait_done("t2_done_seen", 20);
    chk("t2_req_low_in_release", req, 0);
    chk("t2_busy_in_release", busy, 1);
    grant = 1'b0;
    step();
    chk("t2_idle_after_gap", busy, 0);

    // len=4 with preemption pattern 1,1,0,0,1,1
    q0.push_back('{8'd1, 8'd4});
    issue_start(4'd4);
    grant = 1'b1;
    step();
    pat = 6'b110011;
    for (int i = 0; i < 6; i++) begin
      grant = pat[5-i];
      smp();
      chk("t3_xfer_follows_grant", xfer_en, pat[5-i]);
      chk("t3_req_held", req, 1);
      step();
    end
    chk("t3_done", done, 1);
    chk("t3_req_low", req, 0);
    grant = 1'b0;
    step();
    chk("t3_idle", busy, 0);

    // Timeout: grant held low
    q0.push_back('{8'd2, 8'd0});
    issue_start(4'd2);
    n = 0;
    k = 0;
    while (!timeout_err && k < 40) begin
      if (req) n++;
      step();
      k++;
    end
    chk("t4_tmo_seen", timeout_err, 1);
    chk("t4_req_cycles", n, 16);
    chk("t4_req_low", req, 0);
    chk("t4_no_done", done, 0);
    step();
    chk("t4_idle_after_gap", busy, 0);

    // Async reset after 2 of 5 beats
    issue_start(4'd5);
    grant = 1'b1;
    step();
    step();
    step();
    #1 rest = 1'b1;
    #1;
    chk("t5_req_async_drop", req, 0);
    chk("t5_busy_async_drop", busy, 0);
    chk("t5_xfer_async_drop", xfer_en, 0);
    chk("t5_no_done", done, 0);
    step();
    rest  = 1'b0;
    grant = 1'b0;
    smp();
    chk("t5_idle_after_reset", busy, 0);
    step();
    q0.push_back('{8'd1, 8'd5});
    issue_start(4'd5);
    grant = 1'b1;
    wait_done("t5_fresh_done", 20);
    grant = 1'b0;
    step();
    chk("t5_fresh_idle", busy, 0);

    // Ignored starts: len=0 in IDLE, start during REQ and XFER
    issue_start(4'd0);
    smp();
    chk("t6_len0_ignored", {req, busy}, 0);
    step();
    q0.push_back('{8'd1, 8'd3});
    issue_start(4'd3);
    issue_start(4'd7);
    grant = 1'b1;
    step();
    issue_start(4'd9);
    wait_done("t6_done", 20);
    grant = 1'b0;
    step();
    chk("t6_idle", busy, 0);
    step();
    step();
    chk("t6_no_restart", busy, 0);

    // Two requesters against the arbiter model
    arb_mode = 1'b1;
    q0.push_back('{8'd1, 8'd3});
    q1.push_back('{8'd1, 8'd4});
    start = 1'b1; burst_len = 4'd3;
    start1 = 1'b1; len1 = 4'd4;
    step();
    start = 1'b0; start1 = 1'b0;
    k = 0;
    while ((busy || busy1) && k < 80) begin
      step();
      k++;
    end
    chk("t7_both_idle", busy | busy1, 0);
    arb_mode = 1'b0;
    step();

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
